// File: rtl/streebog_l_transform_ctrl_if.sv
// Bus bundle for the Streebog L-transform sequencer: start/ready handshake,
// 512-bit state in/out and the address/data pair of the shared A-matrix mask ROM.
interface streebog_l_transform_ctrl_if;
  logic         ena;
  logic         rdy;
  logic [511:0] din;
  logic [511:0] dout;
  logic [5:0]   rom_addr;
  logic [63:0]  rom_data;

  // master = the surrounding LPS datapath plus the ROM; slave = the sequencer
  modport master (
    output ena,
    output din,
    output rom_data,
    input  rdy,
    input  dout,
    input  rom_addr
  );

  modport slave (
    input  ena,
    input  din,
    input  rom_data,
    output rdy,
    output dout,
    output rom_addr
  );
endinterface

// File: rtl/streebog_l_transform_ctrl.sv
// Streebog linear transform L over eight 64-bit words: walks the 64 rows of the
// registered A-matrix mask ROM and builds one output bit per row for all words.
module streebog_l_transform_ctrl (
  input logic                        clk,
  input logic                        rst_n,
  streebog_l_transform_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [511:0] x_reg;
  logic [511:0] y_acc;
  logic [511:0] y_nxt;
  logic [511:0] dout_reg;
  logic [5:0]   addr_cnt;
  logic [6:0]   cap_cnt;
  logic         rdy_reg;
  logic         accept;
  logic         capture;
  logic         last_cap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ROM data lags the address by one edge, so the first RUN edge (addr_cnt
  // still 0) has nothing to capture; every later edge captures one bit.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    last_cap  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ena) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        capture  = (addr_cnt != 6'd0);
        last_cap = capture && (cap_cnt == 7'd63);
        if (last_cap) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    y_nxt = y_acc;
    for (int w = 0; w < 8; w++) begin
      y_nxt[{3'(w), cap_cnt[5:0]}] = ^(x_reg[{3'(w), 6'd0} +: 64] & bus.rom_data);
    end
  end

  // dout is loaded from y_nxt so the final bit lands in the same edge as rdy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg    <= '0;
      y_acc    <= '0;
      dout_reg <= '0;
      addr_cnt <= '0;
      cap_cnt  <= '0;
      rdy_reg  <= 1'b1;
    end else if (accept) begin
      x_reg    <= bus.din;
      y_acc    <= '0;
      addr_cnt <= '0;
      cap_cnt  <= '0;
      rdy_reg  <= 1'b0;
    end else if (state == RUN) begin
      if (addr_cnt != 6'd63) begin
        addr_cnt <= addr_cnt + 6'd1;
      end
      if (capture) begin
        y_acc   <= y_nxt;
        cap_cnt <= cap_cnt + 7'd1;
      end
      if (last_cap) begin
        dout_reg <= y_nxt;
        rdy_reg  <= 1'b1;
      end
    end
  end

  assign bus.rdy      = rdy_reg;
  assign bus.dout     = dout_reg;
  assign bus.rom_addr = addr_cnt;

endmodule

// File: tb/tb_streebog_l_transform_ctrl.sv
// Directed bench for streebog_l_transform_ctrl: a registered ROM holding the
// transposed A matrix, a row-wise reference model of L and a result scoreboard.
module tb_streebog_l_transform_ctrl;

  localparam logic [63:0] A_ROWS [64] = '{
    64'h8e20faa72ba0b470, 64'h47107ddd9b505a38, 64'had08b0e0c3282d1c, 64'hd8045870ef14980e,
    64'h6c022c38f90a4c07, 64'h3601161cf205268d, 64'h1b8e0b0e798c13c8, 64'h83478b07b2468764,
    64'ha011d380818e8f40, 64'h5086e740ce47c920, 64'h2843fd2067adea10, 64'h14aff010bdd87508,
    64'h0ad97808d06cb404, 64'h05e23c0468365a02, 64'h8c711e02341b2d01, 64'h46b60f011a83988e,
    64'h90dab52a387ae76f, 64'h486dd4151c3dfdb9, 64'h24b86a840e90f0d2, 64'h125c354207487869,
    64'h092e94218d243cba, 64'h8a174a9ec8121e5d, 64'h4585254f64090fa0, 64'haccc9ca9328a8950,
    64'h9d4df05d5f661451, 64'hc0a878a0a1330aa6, 64'h60543c50de970553, 64'h302a1e286fc58ca7,
    64'h18150f14b9ec46dd, 64'h0c84890ad27623e0, 64'h0642ca05693b9f70, 64'h0321658cba93c138,
    64'h86275df09ce8aaa8, 64'h439da0784e745554, 64'hafc0503c273aa42a, 64'hd960281e9d1d5215,
    64'he230140fc0802984, 64'h71180a8960409a42, 64'hb60c05ca30204d21, 64'h5b068c651810a89e,
    64'h456c34887a3805b9, 64'hac361a443d1c8cd2, 64'h561b0d22900e4669, 64'h2b838811480723ba,
    64'h9bcf4486248d9f5d, 64'hc3e9224312c8c1a0, 64'heffa11af0964ee50, 64'hf97d86d98a327728,
    64'he4fa2054a80b329c, 64'h727d102a548b194e, 64'h39b008152acb8227, 64'h9258048415eb419d,
    64'h492c024284fbaec0, 64'haa16012142f35760, 64'h550b8e9e21f7a530, 64'ha48b474f9ef5dc18,
    64'h70a6a56e2440598e, 64'h3853dc371220a247, 64'h1ca76e95091051ad, 64'h0edd37c48a08a6d8,
    64'h07e095624504536c, 64'h8d70c431ac02a736, 64'hc83862965601dd1b, 64'h641c314b2b8ee083
  };

  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  rom [64];
  logic [511:0] exp_q [$];
  logic [511:0] last_result;
  int           assert_cnt = 0;
  int           fail_cnt   = 0;

  always #5 clk = ~clk;

  streebog_l_transform_ctrl_if bus ();

  streebog_l_transform_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // registered mask ROM: data for an address appears one edge later
  always @(posedge clk) begin
    bus.rom_data <= rom[bus.rom_addr];
  end

  // L as the sum of A rows selected by set input bits, MSB selecting row 0
  function automatic logic [511:0] l_ref(input logic [511:0] x);
    logic [511:0] y;
    logic [63:0]  acc;
    y = '0;
    for (int w = 0; w < 8; w++) begin
      acc = '0;
      for (int i = 0; i < 64; i++) begin
        if (x[w*64 + 63 - i]) acc = acc ^ A_ROWS[i];
      end
      y[w*64 +: 64] = acc;
    end
    return y;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called on a negedge with rdy high; returns on the negedge where rdy is seen
  // again. hold keeps ena=1 so the next call accepts on the very next edge.
  task automatic applyStimulus(input logic [511:0] d, input bit noisy, input bit hold, input string tag);
    int           lat;
    int           trace_err;
    int           hold_err;
    logic [511:0] exp_v;
    bus.ena = 1'b1;
    bus.din = d;
    exp_q.push_back(l_ref(d));
    @(posedge clk);
    @(negedge clk);
    lat       = -1;
    trace_err = 0;
    hold_err  = 0;
    for (int k = 0; k < 100; k++) begin
      if (bus.rdy === 1'b1) begin
        lat = k;
        break;
      end
      if (bus.rom_addr !== ((k < 63) ? 6'(k) : 6'd63)) trace_err++;
      if (bus.dout !== last_result) hold_err++;
      if (noisy) begin
        bus.ena = 1'($urandom_range(0, 1));
        bus.din = rand512();
      end else if (!hold) begin
        bus.ena = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput({tag, " latency"}, 512'(lat), 512'd65);
    checkOutput({tag, " rom_addr trace errors"}, 512'(trace_err), 512'd0);
    checkOutput({tag, " dout hold errors"}, 512'(hold_err), 512'd0);
    exp_v = exp_q.pop_front();
    checkOutput({tag, " result"}, bus.dout, exp_v);
    last_result = exp_v;
    if (!hold) bus.ena = 1'b0;
  endtask

  initial begin
    logic [511:0] d;
    logic [511:0] a;
    logic [511:0] b;

    for (int k = 0; k < 64; k++) begin
      for (int i = 0; i < 64; i++) begin
        rom[k][63 - i] = A_ROWS[i][k];
      end
    end
    bus.ena     = 1'b0;
    bus.din     = '0;
    last_result = '0;
    rst_n       = 1'b1;

    $display("[TB] reset");
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset rdy", 512'(bus.rdy), 512'd1);
    checkOutput("reset dout", bus.dout, '0);
    checkOutput("reset rom_addr", 512'(bus.rom_addr), 512'd0);

    applyStimulus('0, 1'b0, 1'b0, "zero");
    @(negedge clk);

    $display("[TB] single bit, word 0 and word 3");
    d = '0;
    d[63] = 1'b1;
    applyStimulus(d, 1'b0, 1'b0, "bit63 w0");
    checkOutput("bit63 w0 const", bus.dout, {448'd0, 64'h8E20FAA72BA0B470});
    @(negedge clk);
    d = '0;
    d[255] = 1'b1;
    applyStimulus(d, 1'b0, 1'b0, "bit63 w3");
    checkOutput("bit63 w3 const", bus.dout, {256'd0, 64'h8E20FAA72BA0B470, 192'd0});
    @(negedge clk);

    $display("[TB] linearity");
    a = rand512();
    b = rand512();
    applyStimulus(a, 1'b0, 1'b0, "lin a");
    @(negedge clk);
    applyStimulus(b, 1'b0, 1'b0, "lin b");
    @(negedge clk);
    applyStimulus(a ^ b, 1'b0, 1'b0, "lin a^b");
    checkOutput("lin L(a^b)=L(a)^L(b)", bus.dout, l_ref(a) ^ l_ref(b));
    @(negedge clk);

    $display("[TB] busy-ignore with noisy inputs");
    applyStimulus(rand512(), 1'b1, 1'b0, "noisy");
    @(negedge clk);

    $display("[TB] back-to-back");
    for (int j = 0; j < 4; j++) begin
      applyStimulus(rand512(), 1'b0, 1'b1, $sformatf("b2b%0d", j));
    end
    bus.ena = 1'b0;
    @(negedge clk);

    $display("[TB] reset mid-operation");
    bus.ena = 1'b1;
    bus.din = rand512();
    @(posedge clk);
    @(negedge clk);
    bus.ena = 1'b0;
    repeat (29) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort rdy", 512'(bus.rdy), 512'd1);
    checkOutput("abort dout", bus.dout, '0);
    checkOutput("abort rom_addr", 512'(bus.rom_addr), 512'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    last_result = '0;
    applyStimulus(rand512(), 1'b0, 1'b0, "post-abort");
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
